gemm_mac_seq_ctrl: RTL and testbench
====================================

Name: gemm_mac_seq_ctrl

Overview:
Sequencer for one output-stationary MAC PE or a PE array: it runs one accumulation job of K operand beats per start. It drives the PE valid, init-save and clear controls from an operand-stream handshake. It then presents the accumulated result with a valid/ready handshake and optionally clears the accumulators. Control outputs are broadcast to every PE in the array.

Parameters:
CntWidth, 16, width of the K beat count and beat counter; max job length 2^CntWidth-1.
ClrOnDone, 1, 1 = one-cycle pe_acc_clr_o after result handshake; 0 = accumulators hold after job.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
start_i  in  1  start job; sampled only in IDLE
k_beats_i  in  CntWidth  operand beats in job; sampled with start_i
abort_i  in  1  synchronous abort of running job
op_valid_i  in  1  A and B operand beats both present at PE inputs
op_ready_o  out  1  controller accepts operand beat
pe_valid_o  out  1  to PE a_valid_i and b_valid_i
pe_init_save_o  out  1  to PE init_save_i
pe_acc_clr_o  out  1  to PE acc_clr_i
res_valid_o  out  1  PE c_o holds final job result
res_ready_i  in  1  result consumer accepts
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse on result handshake
err_o  out  1  one-cycle pulse: start_i with k_beats_i == 0
beat_cnt_o  out  CntWidth  beats accepted so far in current job

Behaviour:
- Reset: asynchronous, active-low on rst_ni; clock clk_i. On reset: state IDLE, counter 0, latched K 0, and every output 0 (op_ready_o, pe_*, res_valid_o, busy_o, done_o, err_o, beat_cnt_o). Reset mid-job abandons the job; no clear pulse is issued.
- States: IDLE, ACC, RESULT, CLR.
- IDLE:
  - start_i=1, k_beats_i>0: latch K, counter := 0, go to ACC next cycle.
  - start_i=1, k_beats_i==0: err_o=1 for one cycle; stay in IDLE.
- ACC:
  - op_ready_o=1. A beat is accepted when op_valid_i && op_ready_o.
  - pe_valid_o = accepted (combinational). pe_init_save_o = accepted && counter==0. On the first beat both are asserted; PE priority lets init_save win.
  - Each accepted beat increments the counter.
  - Accepted beat with counter==K-1 goes to RESULT next cycle. K=1 gives init_save and last beat in the same cycle.
  - op_valid_i gaps stall the job with no limit; no PE control is asserted during a gap.
- RESULT:
  - Entered the cycle after the last beat, when PE c_o is already updated (1-cycle latency).
  - res_valid_o=1 and is held stable until res_ready_i. op_ready_o=0.
  - On handshake: done_o pulses in that cycle; go to CLR if ClrOnDone, else IDLE.
- CLR: pe_acc_clr_o=1 for exactly one cycle, then IDLE.
- abort_i: in ACC or RESULT, go to CLR next cycle regardless of ClrOnDone. No done_o. Any beat accepted in the abort cycle is still forwarded to the PE. In CLR or IDLE, abort_i is ignored.
- start_i outside IDLE is ignored; no queueing.
- Priority: reset > abort_i > normal transitions.
- beat_cnt_o holds its final value in RESULT/CLR and resets to 0 on the next start.
- Never assert pe_valid_o or pe_init_save_o outside ACC.
- Never assert pe_acc_clr_o outside CLR.
- Counter comparison is unsigned at CntWidth bits and never wraps, since K ≤ 2^CntWidth-1.

Decomposition:
- Package gemm_ctrl_pkg: state enum (IDLE, ACC, RESULT, CLR) as a 2-bit typedef, and a default CntWidth constant.
- No sub-module: FSM, beat counter and handshake logic live in one module of about 150-250 lines.

Test Plan:
- K=4, op_valid_i constantly 1, res_ready_i=1 -> init_save in cycle 1 only; pe_valid_o for 4 cycles; res_valid_o in cycle 5 with PE c_o = Σa·b (a=b=1..4 gives 30); done_o pulse; pe_acc_clr_o in cycle 6; PE c_o=0.
- K=1, a=3, b=-5 -> init_save and pe_valid_o in the same cycle; result -15; busy_o lasts 3 cycles including CLR.
- K=3 with op_valid_i pattern 1,0,0,1,0,1 -> exactly 3 pe_valid_o pulses, beat_cnt_o 1,1,1,2,2,3; RESULT entered after the 6th cycle.
- res_ready_i held 0 for 5 cycles -> res_valid_o and PE c_o stable; no done_o until res_ready_i=1; then done_o for 1 cycle.
- abort_i after 2 of 5 beats -> CLR next cycle, PE c_o=0, no done_o, IDLE afterwards; a new K=2 job then gives the correct result.
- start_i with K=0 -> err_o pulse and busy_o stays 0. start_i during ACC -> ignored, K unchanged. Reset asserted mid-ACC -> all outputs 0 immediately.

Source files
------------

// File: rtl/gemm_mac_seq_ctrl_pkg.sv
// ============================================================================
//  Module   : gemm_ctrl_pkg
//  Brief    : Shared types and constants for the GEMM MAC sequencer
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gemm_ctrl_pkg;

  // Default width of the K beat count and the beat counter
  localparam int unsigned c_cnt_width = 16;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    RESULT = 2'd2,
    CLR    = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/gemm_mac_seq_ctrl_if.sv
// ============================================================================
//  Module   : gemm_mac_seq_ctrl_if
//  Brief    : Operand-stream and result handshakes of the MAC sequencer
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gemm_mac_seq_ctrl_if;

  logic op_valid;   // A and B operand beats both present at PE inputs
  logic op_ready;   // sequencer accepts the operand beat
  logic res_valid;  // PE c_o holds the final job result
  logic res_ready;  // result consumer accepts

  // Operand producer / result consumer side
  modport master (
    output op_valid,
    output res_ready,
    input  op_ready,
    input  res_valid
  );

  // Sequencer side
  modport slave (
    input  op_valid,
    input  res_ready,
    output op_ready,
    output res_valid
  );

endinterface

`default_nettype wire

// File: rtl/gemm_mac_seq_ctrl.sv
// ============================================================================
//  Module   : gemm_mac_seq_ctrl
//  Brief    : Runs one K-beat output-stationary MAC job per start, drives the
//             broadcast PE valid / init-save / clear controls and presents the
//             result through a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gemm_mac_seq_ctrl
  import gemm_ctrl_pkg::*;
#(
  parameter int unsigned CntWidth  = c_cnt_width,
  parameter bit          ClrOnDone = 1'b1
) (
  input  wire logic                clk_i,
  input  wire logic                rst_ni,
  input  wire logic                start_i,
  input  wire logic [CntWidth-1:0] k_beats_i,
  input  wire logic                abort_i,
  gemm_mac_seq_ctrl_if.slave       hs,
  output logic                     pe_valid_o,
  output logic                     pe_init_save_o,
  output logic                     pe_acc_clr_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [CntWidth-1:0]      beat_cnt_o
);

  localparam logic [CntWidth-1:0] c_one = {{(CntWidth-1){1'b0}}, 1'b1};

  state_e              r_state;
  state_e              w_state_next;
  logic [CntWidth-1:0] r_cnt;
  logic [CntWidth-1:0] r_k;
  logic                r_err;

  logic w_accept;
  logic w_last;
  logic w_start_ok;
  logic w_start_bad;
  logic w_handshake;

  // Decode beat acceptance, job start and result handshake
  always_comb begin
    w_accept    = (r_state == ACC) && hs.op_valid;
    w_last      = w_accept && (r_cnt == (r_k - c_one));
    w_start_ok  = (r_state == IDLE) && start_i && (k_beats_i != '0);
    w_start_bad = (r_state == IDLE) && start_i && (k_beats_i == '0);
    w_handshake = (r_state == RESULT) && hs.res_ready;
  end

  // Next-state selection; abort takes priority over normal progress
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_ok) w_state_next = ACC;
      end
      ACC: begin
        if (abort_i)     w_state_next = CLR;
        else if (w_last) w_state_next = RESULT;
      end
      RESULT: begin
        if (abort_i)          w_state_next = CLR;
        else if (w_handshake) w_state_next = ClrOnDone ? CLR : IDLE;
      end
      CLR:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State, latched K, beat counter and registered error pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_k     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_start_bad;
      if (w_start_ok) begin
        r_k   <= k_beats_i;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + c_one;
      end
    end
  end

  // Broadcast PE controls and status; beats in an abort cycle still reach the PE
  always_comb begin
    hs.op_ready    = (r_state == ACC);
    hs.res_valid   = (r_state == RESULT);
    pe_valid_o     = w_accept;
    pe_init_save_o = w_accept && (r_cnt == '0);
    pe_acc_clr_o   = (r_state == CLR);
    busy_o         = (r_state != IDLE);
    done_o         = w_handshake && !abort_i;
    err_o          = r_err;
    beat_cnt_o     = r_cnt;
  end

endmodule

`default_nettype wire

// File: tb/tb_gemm_mac_seq_ctrl.sv
// ============================================================================
//  Module   : tb_gemm_mac_seq_ctrl
//  Brief    : Directed self-checking bench for gemm_mac_seq_ctrl with a small
//             behavioural MAC PE attached to the broadcast controls.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gemm_mac_seq_ctrl;

  localparam int unsigned c_w = 16;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [c_w-1:0] k_beats;
  logic           abort;
  logic           pe_valid;
  logic           pe_init_save;
  logic           pe_acc_clr;
  logic           busy;
  logic           done;
  logic           err;
  logic [c_w-1:0] beat_cnt;

  logic signed [15:0] a_op;
  logic signed [15:0] b_op;
  logic signed [31:0] pe_acc;

  int n_cmp = 0;
  int n_err = 0;

  logic pat     [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int   exp_cnt [6] = '{1, 1, 1, 2, 2, 3};

  gemm_mac_seq_ctrl_if hs_if ();

  gemm_mac_seq_ctrl #(
    .CntWidth  (c_w),
    .ClrOnDone (1'b1)
  ) u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .k_beats_i      (k_beats),
    .abort_i        (abort),
    .hs             (hs_if),
    .pe_valid_o     (pe_valid),
    .pe_init_save_o (pe_init_save),
    .pe_acc_clr_o   (pe_acc_clr),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err),
    .beat_cnt_o     (beat_cnt)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural output-stationary PE: clear > init-save > accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            pe_acc <= '0;
    else if (pe_acc_clr)   pe_acc <= '0;
    else if (pe_init_save) pe_acc <= a_op * b_op;
    else if (pe_valid)     pe_acc <= pe_acc + a_op * b_op;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; k_beats = '0; abort = 1'b0;
    hs_if.op_valid = 1'b0; hs_if.res_ready = 1'b0; a_op = '0; b_op = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy",      32'(busy), 0);
    check_eq("rst_op_ready",  32'(hs_if.op_ready), 0);
    check_eq("rst_res_valid", 32'(hs_if.res_valid), 0);
    check_eq("rst_pe_ctrl",   32'({pe_valid, pe_init_save, pe_acc_clr}), 0);
    check_eq("rst_done_err",  32'({done, err}), 0);
    check_eq("rst_beat_cnt",  32'(beat_cnt), 0);
    rst_n = 1'b1;
    tick();

    // K=4, a=b=1..4, continuous valid -> 30
    start = 1'b1; k_beats = 16'd4; #1;
    check_eq("k4_busy_idle", 32'(busy), 0);
    tick();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      hs_if.op_valid = 1'b1; a_op = 16'(i); b_op = 16'(i); #1;
      check_eq("k4_pe_valid",  32'(pe_valid), 1);
      check_eq("k4_init_save", 32'(pe_init_save), (i == 1) ? 1 : 0);
      check_eq("k4_beat_cnt",  32'(beat_cnt), 32'(i - 1));
      tick();
    end
    hs_if.op_valid = 1'b0; hs_if.res_ready = 1'b1; #1;
    check_eq("k4_res_valid", 32'(hs_if.res_valid), 1);
    check_eq("k4_op_ready",  32'(hs_if.op_ready), 0);
    check_eq("k4_result",    32'(pe_acc), 32'd30);
    check_eq("k4_done",      32'(done), 1);
    tick();
    hs_if.res_ready = 1'b0; #1;
    check_eq("k4_clr",      32'(pe_acc_clr), 1);
    check_eq("k4_done_off", 32'(done), 0);
    check_eq("k4_no_valid", 32'(pe_valid), 0);
    tick();
    check_eq("k4_idle",    32'(busy), 0);
    check_eq("k4_cleared", 32'(pe_acc), 0);

    // K=1, 3 * -5 -> -15, busy for ACC/RESULT/CLR
    start = 1'b1; k_beats = 16'd1; tick();
    start = 1'b0; hs_if.op_valid = 1'b1; a_op = 16'sd3; b_op = -16'sd5; #1;
    check_eq("k1_init_valid", 32'({pe_init_save, pe_valid}), 32'b11);
    check_eq("k1_busy1",      32'(busy), 1);
    tick();
    hs_if.op_valid = 1'b0; hs_if.res_ready = 1'b1; #1;
    check_eq("k1_result", 32'(pe_acc), 32'hFFFF_FFF1);
    check_eq("k1_done",   32'(done), 1);
    check_eq("k1_busy2",  32'(busy), 1);
    tick();
    hs_if.res_ready = 1'b0; #1;
    check_eq("k1_clr",   32'(pe_acc_clr), 1);
    check_eq("k1_busy3", 32'(busy), 1);
    tick();
    check_eq("k1_idle", 32'(busy), 0);

    // K=3 with valid gaps, then result back-pressure for 5 cycles
    start = 1'b1; k_beats = 16'd3; tick();
    start = 1'b0; a_op = 16'sd1; b_op = 16'sd1;
    for (int i = 0; i < 6; i++) begin
      hs_if.op_valid = pat[i]; #1;
      check_eq("gap_pe_valid", 32'(pe_valid), 32'(pat[i]));
      check_eq("gap_res_wait", 32'(hs_if.res_valid), 0);
      tick();
      check_eq("gap_beat_cnt", 32'(beat_cnt), 32'(exp_cnt[i]));
    end
    hs_if.op_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp_res_valid", 32'(hs_if.res_valid), 1);
      check_eq("bp_result",    32'(pe_acc), 32'd3);
      check_eq("bp_no_done",   32'(done), 0);
      tick();
    end
    hs_if.res_ready = 1'b1; #1;
    check_eq("bp_done", 32'(done), 1);
    tick();
    hs_if.res_ready = 1'b0; #1;
    check_eq("bp_done_once", 32'(done), 0);
    check_eq("bp_clr",       32'(pe_acc_clr), 1);
    tick();

    // Abort after 2 of 5 beats, then a fresh K=2 job with an ignored start
    start = 1'b1; k_beats = 16'd5; tick();
    start = 1'b0; a_op = 16'sd2; b_op = 16'sd2;
    hs_if.op_valid = 1'b1; tick();
    tick();
    hs_if.op_valid = 1'b0; abort = 1'b1; hs_if.res_ready = 1'b1; #1;
    check_eq("ab_no_done", 32'(done), 0);
    check_eq("ab_partial", 32'(pe_acc), 32'd8);
    tick();
    abort = 1'b0; hs_if.res_ready = 1'b0; #1;
    check_eq("ab_clr",       32'(pe_acc_clr), 1);
    check_eq("ab_res_valid", 32'(hs_if.res_valid), 0);
    check_eq("ab_done_clr",  32'(done), 0);
    tick();
    check_eq("ab_idle",    32'(busy), 0);
    check_eq("ab_cleared", 32'(pe_acc), 0);
    start = 1'b1; k_beats = 16'd2; tick();
    k_beats = 16'd7;
    hs_if.op_valid = 1'b1; a_op = 16'sd2; b_op = 16'sd3; #1;
    check_eq("re_init_save", 32'(pe_init_save), 1);
    tick();
    start = 1'b0; a_op = 16'sd4; b_op = 16'sd5; tick();
    hs_if.op_valid = 1'b0; #1;
    check_eq("re_k_kept",   32'(hs_if.res_valid), 1);
    check_eq("re_result",   32'(pe_acc), 32'd26);
    check_eq("re_beat_cnt", 32'(beat_cnt), 32'd2);
    hs_if.res_ready = 1'b1; tick();
    hs_if.res_ready = 1'b0; tick();

    // start with K=0 -> error pulse, stays idle
    start = 1'b1; k_beats = 16'd0; tick();
    start = 1'b0; #1;
    check_eq("k0_err",  32'(err), 1);
    check_eq("k0_busy", 32'(busy), 0);
    tick();
    check_eq("k0_err_once", 32'(err), 0);

    // Reset asserted mid-ACC clears all outputs immediately
    start = 1'b1; k_beats = 16'd4; tick();
    start = 1'b0; hs_if.op_valid = 1'b1; a_op = 16'sd1; b_op = 16'sd1; tick();
    rst_n = 1'b0; #1;
    check_eq("mr_busy",     32'(busy), 0);
    check_eq("mr_op_ready", 32'(hs_if.op_ready), 0);
    check_eq("mr_pe_ctrl",  32'({pe_valid, pe_init_save, pe_acc_clr}), 0);
    check_eq("mr_beat_cnt", 32'(beat_cnt), 0);
    hs_if.op_valid = 1'b0; rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
